fr_car_queue_dispatch: RTL and testbench

Producer end of the farm-road straight-car animation handshake. Counts cars arriving at the farm-road stop line from a board button. While the farm-road straight light is green, it releases them one at a time by asserting `add_car` to the left-to-right car animator, and consumes one car per `decrement_car` acknowledge. The count drives the waiting-car display, and `queue_empty` feeds the light controller's sensor input.

---
 rtl/traffic_pkg.sv | 13 +
 rtl/sync_rise_detect.sv | 28 ++
 rtl/fr_car_queue_dispatch.sv | 87 ++++++++
 tb/tb_fr_car_queue_dispatch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and defaults for the farm-road and main-road car dispatchers.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    GAP
  } dispatch_state_t;

  localparam int unsigned MAX_CARS_DEFAULT   = 9;
  localparam int unsigned GAP_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer for an asynchronous level input, plus a delay stage
// that turns each synchronized rising edge into a one-cycle pulse.
module sync_rise_detect (
  input  logic traffic_clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_c
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge traffic_clk) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise_c = sync2 & ~sync3;

endmodule

// File: rtl/fr_car_queue_dispatch.sv
// Farm-road car queue: counts button arrivals and releases cars one at a time
// to the animator while the farm-road straight light is green.
module fr_car_queue_dispatch
  import traffic_pkg::*;
#(
  parameter int unsigned MAX_CARS   = MAX_CARS_DEFAULT,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             traffic_clk,
  input  logic             reset_n,
  input  logic             car_arrive,
  input  logic             fr_green,
  input  logic             decrement_car,
  output logic             add_car,
  output logic [CNT_W-1:0] car_count,
  output logic             queue_empty,
  output logic             queue_full
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  dispatch_state_t state;
  logic [GAP_W-1:0] gap_cnt;
  logic             arrive_pulse;

  sync_rise_detect u_arrive_sync (
    .traffic_clk (traffic_clk),
    .reset_n     (reset_n),
    .async_in    (car_arrive),
    .rise_c      (arrive_pulse)
  );

  assign queue_empty = (car_count == '0);
  assign queue_full  = (car_count == CNT_W'(MAX_CARS));

  // Arrival and acknowledge in the same cycle cancel, even at full or empty.
  always_ff @(posedge traffic_clk) begin
    if (!reset_n) begin
      car_count <= '0;
    end else if (arrive_pulse && !decrement_car && !queue_full) begin
      car_count <= car_count + CNT_W'(1);
    end else if (decrement_car && !arrive_pulse && !queue_empty) begin
      car_count <= car_count - CNT_W'(1);
    end
  end

  // Dispatch FSM; add_car is registered alongside the state and mirrors REQUEST.
  always_ff @(posedge traffic_clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      add_car <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fr_green && !queue_empty) begin
            state   <= REQUEST;
            add_car <= 1'b1;
          end
        end
        REQUEST: begin
          if (decrement_car) begin
            state   <= GAP;
            add_car <= 1'b0;
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
          end else if (!fr_green) begin
            state   <= IDLE;
            add_car <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          add_car <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fr_car_queue_dispatch.sv
// Directed bench for the farm-road car queue dispatcher.
module tb_fr_car_queue_dispatch;

  logic       traffic_clk;
  logic       reset_n;
  logic       car_arrive;
  logic       fr_green;
  logic       decrement_car;
  logic       add_car;
  logic [3:0] car_count;
  logic       queue_empty;
  logic       queue_full;

  int n_checks;
  int n_fail;

  fr_car_queue_dispatch #(
    .MAX_CARS   (9),
    .GAP_CYCLES (4),
    .CNT_W      (4)
  ) dut (
    .traffic_clk   (traffic_clk),
    .reset_n       (reset_n),
    .car_arrive    (car_arrive),
    .fr_green      (fr_green),
    .decrement_car (decrement_car),
    .add_car       (add_car),
    .car_count     (car_count),
    .queue_empty   (queue_empty),
    .queue_full    (queue_full)
  );

  initial traffic_clk = 1'b0;
  always #5 traffic_clk = ~traffic_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge traffic_clk);
  endtask

  task automatic press();
    car_arrive = 1'b1;
    repeat (3) tick();
    car_arrive = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Arrival with an acknowledge landing on the same edge that consumes the pulse.
  task automatic simultaneous();
    car_arrive = 1'b1;
    tick();
    tick();
    decrement_car = 1'b1;
    tick();
    decrement_car = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (4) tick();
    n_checks++; if (add_car !== 1'b0) begin n_fail++; $display("FAIL reset_add_car: got %b expected 0", add_car); end
    n_checks++; if (car_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", car_count); end
    n_checks++; if (queue_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", queue_empty); end
    n_checks++; if (queue_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", queue_full); end
    reset_n = 1'b1;
    tick();
    car_arrive = 1'b1;
    tick();
    tick();
    n_checks++; if (car_count !== 4'd0) begin n_fail++; $display("FAIL arrive_latency_2: got %0d expected 0", car_count); end
    tick();
    n_checks++; if (car_count !== 4'd1) begin n_fail++; $display("FAIL arrive_latency_3: got %0d expected 1", car_count); end
    car_arrive = 1'b0;
    repeat (3) tick();
    press();
    press();
    n_checks++; if (car_count !== 4'd3) begin n_fail++; $display("FAIL count_three: got %0d expected 3", car_count); end
    n_checks++; if (add_car !== 1'b0) begin n_fail++; $display("FAIL no_req_red: got %b expected 0", add_car); end
  endtask

  task automatic test_dispatch();
    int rises[$];
    int falls;
    int seen;
    logic prev_add;
    falls = 0;
    seen = 0;
    prev_add = 1'b0;
    fr_green = 1'b1;
    tick();
    n_checks++; if (add_car !== 1'b1) begin n_fail++; $display("FAIL req_latency: got %b expected 1", add_car); end
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (add_car && !prev_add) rises.push_back(cyc);
      if (!add_car && prev_add) begin
        n_checks++;
        if (car_count !== 4'(3 - falls - 1)) begin
          n_fail++; $display("FAIL dispatch_step%0d: got %0d expected %0d", falls, car_count, 3 - falls - 1);
        end
        falls++;
      end
      if (decrement_car) begin
        decrement_car = 1'b0;
      end else if (add_car) begin
        seen++;
        if (seen == 2) begin
          decrement_car = 1'b1;
          seen = 0;
        end
      end else begin
        seen = 0;
      end
      prev_add = add_car;
      tick();
    end
    n_checks++; if (rises.size() != 3) begin n_fail++; $display("FAIL dispatch_pulses: got %0d expected 3", rises.size()); end
    for (int i = 1; i < rises.size(); i++) begin
      n_checks++;
      if (rises[i] - rises[i-1] < 6) begin
        n_fail++; $display("FAIL dispatch_spacing%0d: got %0d expected >=6", i, rises[i] - rises[i-1]);
      end
    end
    n_checks++; if (car_count !== 4'd0) begin n_fail++; $display("FAIL dispatch_final_count: got %0d expected 0", car_count); end
    n_checks++; if (queue_empty !== 1'b1) begin n_fail++; $display("FAIL dispatch_empty: got %b expected 1", queue_empty); end
    n_checks++; if (add_car !== 1'b0) begin n_fail++; $display("FAIL dispatch_idle: got %b expected 0", add_car); end
    fr_green = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    pulse_reset();
    repeat (12) press();
    n_checks++; if (car_count !== 4'd9) begin n_fail++; $display("FAIL sat_count: got %0d expected 9", car_count); end
    n_checks++; if (queue_full !== 1'b1) begin n_fail++; $display("FAIL sat_full: got %b expected 1", queue_full); end
    n_checks++; if (queue_empty !== 1'b0) begin n_fail++; $display("FAIL sat_empty: got %b expected 0", queue_empty); end
    press();
    n_checks++; if (car_count !== 4'd9) begin n_fail++; $display("FAIL sat_extra: got %0d expected 9", car_count); end
  endtask

  task automatic test_held_once();
    pulse_reset();
    car_arrive = 1'b1;
    repeat (10) tick();
    car_arrive = 1'b0;
    repeat (3) tick();
    n_checks++; if (car_count !== 4'd1) begin n_fail++; $display("FAIL held_once: got %0d expected 1", car_count); end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    repeat (5) press();
    simultaneous();
    n_checks++; if (car_count !== 4'd5) begin n_fail++; $display("FAIL simul_mid: got %0d expected 5", car_count); end
    car_arrive = 1'b0;
    repeat (3) tick();
    n_checks++; if (car_count !== 4'd5) begin n_fail++; $display("FAIL simul_mid_after: got %0d expected 5", car_count); end
    repeat (4) press();
    simultaneous();
    n_checks++; if (car_count !== 4'd9) begin n_fail++; $display("FAIL simul_full: got %0d expected 9", car_count); end
    car_arrive = 1'b0;
    repeat (3) tick();
    decrement_car = 1'b1;
    tick();
    decrement_car = 1'b0;
    tick();
    n_checks++; if (car_count !== 4'd8) begin n_fail++; $display("FAIL dec_from_full: got %0d expected 8", car_count); end
  endtask

  task automatic test_abort();
    pulse_reset();
    press();
    press();
    fr_green = 1'b1;
    tick();
    tick();
    n_checks++; if (add_car !== 1'b1) begin n_fail++; $display("FAIL abort_req: got %b expected 1", add_car); end
    fr_green = 1'b0;
    tick();
    n_checks++; if (add_car !== 1'b0) begin n_fail++; $display("FAIL abort_drop: got %b expected 0", add_car); end
    n_checks++; if (car_count !== 4'd2) begin n_fail++; $display("FAIL abort_count: got %0d expected 2", car_count); end
    decrement_car = 1'b1;
    tick();
    decrement_car = 1'b0;
    tick();
    n_checks++; if (car_count !== 4'd1) begin n_fail++; $display("FAIL late_ack: got %0d expected 1", car_count); end
    n_checks++; if (add_car !== 1'b0) begin n_fail++; $display("FAIL late_ack_req: got %b expected 0", add_car); end
  endtask

  task automatic test_reset_mid_request();
    fr_green = 1'b1;
    tick();
    n_checks++; if (add_car !== 1'b1) begin n_fail++; $display("FAIL midreq_req: got %b expected 1", add_car); end
    reset_n = 1'b0;
    tick();
    n_checks++; if (add_car !== 1'b0) begin n_fail++; $display("FAIL midreq_add: got %b expected 0", add_car); end
    n_checks++; if (car_count !== 4'd0) begin n_fail++; $display("FAIL midreq_count: got %0d expected 0", car_count); end
    reset_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (add_car !== 1'b0) begin n_fail++; $display("FAIL midreq_idle: got %b expected 0", add_car); end
    fr_green = 1'b0;
    press();
    fr_green = 1'b1;
    tick();
    n_checks++; if (add_car !== 1'b1) begin n_fail++; $display("FAIL midreq_reidle: got %b expected 1", add_car); end
    fr_green = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset_n = 1'b0;
    car_arrive = 1'b0;
    fr_green = 1'b0;
    decrement_car = 1'b0;
    test_reset();
    test_dispatch();
    test_saturation();
    test_held_once();
    test_simultaneous();
    test_abort();
    test_reset_mid_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
